// File: rtl/tstamp_pkg.sv
// Shared types and constants for the timestamp / TDC7200 front end.
package tstamp_pkg;

   typedef enum logic [1:0] {
      SPI_IDLE    = 2'd0,
      SPI_SETUP   = 2'd1,
      SPI_SCLK_HI = 2'd2,
      SPI_SCLK_LO = 2'd3
   } spi_state_t;

   // Bit counter holds up to 24 (3 bytes x 8 bits).
   localparam int BITCNT_W = 5;

   localparam int TS_W_DEF     = 44;
   localparam int NCH_DEF      = 4;
   localparam int SCLK_DIV_DEF = 4;

endpackage

// File: rtl/tdc_spi_master.sv
// Self-clocked mode-0 SPI master for the TDC7200, 1..3 byte transfers.
//
// state       | meaning
// ------------+-------------------------------------------------------
// SPI_IDLE    | csb high, sclk low, waiting for xfer_start
// SPI_SETUP   | csb low, first bit on tdc_din, before first sclk rise
// SPI_SCLK_HI | sclk high; tdc_dout was sampled on entry
// SPI_SCLK_LO | sclk low; tdc_din advanced on entry; last one is csb hold
module tdc_spi_master
   import tstamp_pkg::*;
#(
   parameter int SCLK_DIV = SCLK_DIV_DEF
) (
   input  logic        tstamp_clk,
   input  logic        tstamp_rst,
   input  logic        xfer_start,
   input  logic [1:0]  xfer_nbytes,
   input  logic [23:0] xfer_tx,
   input  logic        tdc_dout,
   output logic        xfer_busy,
   output logic        xfer_done,
   output logic [23:0] xfer_rx,
   output logic        tdc_sclk,
   output logic        tdc_csb,
   output logic        tdc_din
);

   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SCLK_DIV - 1);

   spi_state_t          state, state_nxt;
   logic [DIV_W-1:0]    div_cnt;
   logic [BITCNT_W-1:0] bit_cnt;
   logic [23:0]         tx_sh;
   logic [23:0]         rx_sh;
   logic                div_tc;
   logic                accept, enter_hi, enter_lo, finish;

   assign div_tc = (div_cnt == '0);

   // State register.
   always_ff @(posedge tstamp_clk) begin
      if (tstamp_rst) state <= SPI_IDLE;
      else            state <= state_nxt;
   end

   // Next-state decode and phase-transition strobes.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      enter_hi  = 1'b0;
      enter_lo  = 1'b0;
      finish    = 1'b0;
      case (state)
         SPI_IDLE: begin
            if (xfer_start && (xfer_nbytes != 2'd0)) begin
               state_nxt = SPI_SETUP;
               accept    = 1'b1;
            end
         end
         SPI_SETUP: begin
            if (div_tc) begin
               state_nxt = SPI_SCLK_HI;
               enter_hi  = 1'b1;
            end
         end
         SPI_SCLK_HI: begin
            if (div_tc) begin
               state_nxt = SPI_SCLK_LO;
               enter_lo  = 1'b1;
            end
         end
         SPI_SCLK_LO: begin
            if (div_tc) begin
               if (bit_cnt == '0) begin
                  state_nxt = SPI_IDLE;
                  finish    = 1'b1;
               end else begin
                  state_nxt = SPI_SCLK_HI;
                  enter_hi  = 1'b1;
               end
            end
         end
         default: state_nxt = SPI_IDLE;
      endcase
   end

   // Phase divider, bit counter and shift registers.
   always_ff @(posedge tstamp_clk) begin
      if (tstamp_rst) begin
         div_cnt   <= '0;
         bit_cnt   <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         xfer_rx   <= '0;
         xfer_done <= 1'b0;
      end else begin
         xfer_done <= finish;
         if (accept || enter_hi || enter_lo) div_cnt <= DIV_RELOAD;
         else if (!div_tc)                   div_cnt <= div_cnt - 1'b1;
         if (accept)        bit_cnt <= {xfer_nbytes, 3'b000};
         else if (enter_lo) bit_cnt <= bit_cnt - 1'b1;
         if (accept)        tx_sh <= xfer_tx;
         else if (enter_lo) tx_sh <= {tx_sh[22:0], 1'b0};
         // Clearing on accept keeps the result right-aligned with zero upper bits.
         if (accept)        rx_sh <= '0;
         else if (enter_hi) rx_sh <= {rx_sh[22:0], tdc_dout};
         if (finish)        xfer_rx <= rx_sh;
      end
   end

   assign xfer_busy = (state != SPI_IDLE);
   assign tdc_csb   = (state == SPI_IDLE);
   assign tdc_sclk  = (state == SPI_SCLK_HI);
   assign tdc_din   = tx_sh[23] && (state != SPI_IDLE);

endmodule

// File: rtl/tstamp_tdc_engine.sv
// Free-running timestamp counter, per-channel hit capture and TDC7200 SPI engine.
module tstamp_tdc_engine
   import tstamp_pkg::*;
#(
   parameter int TS_W     = TS_W_DEF,
   parameter int NCH      = NCH_DEF,
   parameter int SCLK_DIV = SCLK_DIV_DEF
) (
   input  logic                tstamp_clk,
   input  logic                tstamp_rst,
   input  logic                tstamp_clr,
   input  logic [NCH-1:0]      hit,
   input  logic [NCH-1:0]      ch_ack,
   input  logic                xfer_start,
   input  logic [1:0]          xfer_nbytes,
   input  logic [23:0]         xfer_tx,
   input  logic                tdc_dout,
   output logic [TS_W-1:0]     tstamp_counter,
   output logic                tstamp_wrap,
   output logic [NCH*TS_W-1:0] ch_tstamp,
   output logic [NCH-1:0]      ch_valid,
   output logic [NCH-1:0]      ch_overrun,
   output logic                xfer_busy,
   output logic                xfer_done,
   output logic [23:0]         xfer_rx,
   output logic                tdc_sclk,
   output logic                tdc_csb,
   output logic                tdc_din
);

   logic [NCH-1:0] hit_q, hit_qq;

   // Timestamp counter; clear wins over the wrap pulse.
   always_ff @(posedge tstamp_clk) begin
      if (tstamp_rst || tstamp_clr) begin
         tstamp_counter <= '0;
         tstamp_wrap    <= 1'b0;
      end else begin
         tstamp_counter <= tstamp_counter + TS_W'(1);
         tstamp_wrap    <= (tstamp_counter == '1);
      end
   end

   // Hit registration for rising-edge detection.
   always_ff @(posedge tstamp_clk) begin
      if (tstamp_rst) begin
         hit_q  <= '0;
         hit_qq <= '0;
      end else begin
         hit_q  <= hit;
         hit_qq <= hit_q;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [TS_W-1:0] stamp_q;
      logic            valid_q;
      logic            ovr_q;
      logic            hit_rise;

      assign hit_rise = hit_q[i] & ~hit_qq[i];

      // Capture when free or being acked this cycle; otherwise flag the lost hit.
      always_ff @(posedge tstamp_clk) begin
         if (tstamp_rst) begin
            stamp_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
         end else begin
            if (hit_rise && (!valid_q || ch_ack[i])) begin
               stamp_q <= tstamp_counter;
               valid_q <= 1'b1;
            end else if (ch_ack[i]) begin
               valid_q <= 1'b0;
            end
            if (tstamp_clr)                                 ovr_q <= 1'b0;
            else if (hit_rise && valid_q && !ch_ack[i])     ovr_q <= 1'b1;
         end
      end

      assign ch_tstamp[i*TS_W +: TS_W] = stamp_q;
      assign ch_valid[i]               = valid_q;
      assign ch_overrun[i]             = ovr_q;
   end

   tdc_spi_master #(
      .SCLK_DIV (SCLK_DIV)
   ) u_spi (
      .tstamp_clk  (tstamp_clk),
      .tstamp_rst  (tstamp_rst),
      .xfer_start  (xfer_start),
      .xfer_nbytes (xfer_nbytes),
      .xfer_tx     (xfer_tx),
      .tdc_dout    (tdc_dout),
      .xfer_busy   (xfer_busy),
      .xfer_done   (xfer_done),
      .xfer_rx     (xfer_rx),
      .tdc_sclk    (tdc_sclk),
      .tdc_csb     (tdc_csb),
      .tdc_din     (tdc_din)
   );

endmodule

// File: tb/tb_tstamp_tdc_engine.sv
// Directed bench for tstamp_tdc_engine with TS_W=8, NCH=4, SCLK_DIV=2.
module tb_tstamp_tdc_engine;

   localparam int TS_W     = 8;
   localparam int NCH      = 4;
   localparam int SCLK_DIV = 2;

   logic                tstamp_clk = 1'b0;
   logic                tstamp_rst, tstamp_clr;
   logic [NCH-1:0]      hit, ch_ack;
   logic                xfer_start;
   logic [1:0]          xfer_nbytes;
   logic [23:0]         xfer_tx;
   logic                tdc_dout;
   logic [TS_W-1:0]     tstamp_counter;
   logic                tstamp_wrap;
   logic [NCH*TS_W-1:0] ch_tstamp;
   logic [NCH-1:0]      ch_valid, ch_overrun;
   logic                xfer_busy, xfer_done;
   logic [23:0]         xfer_rx;
   logic                tdc_sclk, tdc_csb, tdc_din;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_cnt  = 8'h00;
   logic        exp_wrap = 1'b0;
   int          wrap_seen = 0;

   // TDC model: shifts out tdc_pat MSB first, one bit per sclk rise, or loops din back.
   logic        loopback = 1'b0;
   logic [23:0] tdc_pat  = 24'h0;
   int          rise_cnt = 0;
   logic        sclk_d   = 1'b0;

   tstamp_tdc_engine #(.TS_W(TS_W), .NCH(NCH), .SCLK_DIV(SCLK_DIV)) dut (
      .tstamp_clk     (tstamp_clk),
      .tstamp_rst     (tstamp_rst),
      .tstamp_clr     (tstamp_clr),
      .hit            (hit),
      .ch_ack         (ch_ack),
      .xfer_start     (xfer_start),
      .xfer_nbytes    (xfer_nbytes),
      .xfer_tx        (xfer_tx),
      .tdc_dout       (tdc_dout),
      .tstamp_counter (tstamp_counter),
      .tstamp_wrap    (tstamp_wrap),
      .ch_tstamp      (ch_tstamp),
      .ch_valid       (ch_valid),
      .ch_overrun     (ch_overrun),
      .xfer_busy      (xfer_busy),
      .xfer_done      (xfer_done),
      .xfer_rx        (xfer_rx),
      .tdc_sclk       (tdc_sclk),
      .tdc_csb        (tdc_csb),
      .tdc_din        (tdc_din)
   );

   always #5 tstamp_clk = ~tstamp_clk;

   always @(posedge tstamp_clk) begin
      if (tdc_csb)                  rise_cnt <= 0;
      else if (tdc_sclk && !sclk_d) rise_cnt <= rise_cnt + 1;
      sclk_d <= tdc_sclk;
   end

   always_comb begin
      tdc_dout = 1'b0;
      if (loopback)           tdc_dout = tdc_din;
      else if (rise_cnt < 24) tdc_dout = tdc_pat[23 - rise_cnt];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, update the counter model and compare counter/wrap.
   task automatic step();
      logic       c;
      logic [7:0] old;
      c   = tstamp_clr | tstamp_rst;
      old = exp_cnt;
      @(posedge tstamp_clk);
      #1;
      exp_wrap = !c && (old == 8'hFF);
      exp_cnt  = c ? 8'h00 : old + 8'h01;
      if (tstamp_wrap) wrap_seen++;
      check("cnt", tstamp_counter, exp_cnt);
      check("wrap", tstamp_wrap, exp_wrap);
   endtask

   task automatic wait_cnt(input logic [7:0] t);
      for (int i = 0; i < 300 && exp_cnt != t; i++) step();
      check("wait_cnt", tstamp_counter, t);
   endtask

   task automatic pulse_hit(input int ch);
      hit[ch] = 1'b1;
      step();
      hit[ch] = 1'b0;
   endtask

   task automatic start_xfer(input logic [1:0] nb, input logic [23:0] tx);
      xfer_start  = 1'b1;
      xfer_nbytes = nb;
      xfer_tx     = tx;
      step();
      xfer_start  = 1'b0;
   endtask

   // Follow a transfer until busy drops; optionally fire a stray start at cycle inject_at.
   task automatic watch(input int inject_at, output int ncyc, output int first_rise,
                        output logic [23:0] dbits);
      logic prev;
      ncyc = 0;
      first_rise = -1;
      dbits = 24'h0;
      while (xfer_busy && ncyc < 400) begin
         prev = tdc_sclk;
         if (ncyc == inject_at) begin
            xfer_start  = 1'b1;
            xfer_nbytes = 2'd1;
            xfer_tx     = 24'h000000;
         end
         step();
         xfer_start = 1'b0;
         ncyc++;
         if (tdc_sclk && !prev) begin
            dbits = {dbits[22:0], tdc_din};
            if (first_rise < 0) first_rise = ncyc;
         end
      end
   endtask

   initial begin
      int          ncyc, frise, rises, done_seen;
      logic [23:0] dbits;
      logic        prev;

      tstamp_rst = 1'b1; tstamp_clr = 1'b0;
      hit = '0; ch_ack = '0;
      xfer_start = 1'b0; xfer_nbytes = 2'd0; xfer_tx = 24'h0;
      repeat (3) step();
      check("rst_valid", ch_valid, 0);
      check("rst_overrun", ch_overrun, 0);
      check("rst_tstamp", ch_tstamp, 0);
      check("rst_busy", xfer_busy, 0);
      check("rst_done", xfer_done, 0);
      check("rst_rx", xfer_rx, 0);
      check("rst_sclk", tdc_sclk, 0);
      check("rst_csb", tdc_csb, 1);
      check("rst_din", tdc_din, 0);
      tstamp_rst = 1'b0;

      // Counter wrap and clear
      wrap_seen = 0;
      repeat (260) step();
      check("wrap_count_260", wrap_seen, 1);
      check("cnt_after_260", tstamp_counter, 8'h04);
      wait_cnt(8'd100);
      tstamp_clr = 1'b1; step(); tstamp_clr = 1'b0;
      check("clr_at_100", tstamp_counter, 8'h00);
      wait_cnt(8'hFF);
      wrap_seen = 0;
      tstamp_clr = 1'b1; step(); tstamp_clr = 1'b0;
      check("clr_at_ff_cnt", tstamp_counter, 8'h00);
      check("clr_at_ff_nowrap", wrap_seen, 0);

      // Hit capture
      wait_cnt(8'h10);
      pulse_hit(2);
      check("hit_edge_valid", ch_valid, 4'b0000);
      step();
      check("hit_valid", ch_valid, 4'b0100);
      check("hit_stamp", ch_tstamp[2*TS_W +: TS_W], 8'h11);
      ch_ack[2] = 1'b1; step(); ch_ack[2] = 1'b0;
      check("ack_valid", ch_valid, 4'b0000);
      check("ack_stamp_kept", ch_tstamp[2*TS_W +: TS_W], 8'h11);
      pulse_hit(2); step();
      check("hit2_valid", ch_valid, 4'b0100);
      check("hit2_stamp", ch_tstamp[2*TS_W +: TS_W], 8'h14);
      pulse_hit(2); step();
      check("ovr_stamp_kept", ch_tstamp[2*TS_W +: TS_W], 8'h14);
      check("ovr_flag", ch_overrun, 4'b0100);
      pulse_hit(2);
      ch_ack[2] = 1'b1; step(); ch_ack[2] = 1'b0;
      check("hit_ack_valid", ch_valid, 4'b0100);
      check("hit_ack_stamp", ch_tstamp[2*TS_W +: TS_W], 8'h18);
      check("ovr_sticky", ch_overrun, 4'b0100);
      pulse_hit(0); step();
      check("ch0_stamp", ch_tstamp[0 +: TS_W], 8'h1A);
      check("ch0_valid", ch_valid, 4'b0101);
      tstamp_clr = 1'b1; step(); tstamp_clr = 1'b0;
      check("clr_overrun", ch_overrun, 4'b0000);
      check("clr_keeps_valid", ch_valid, 4'b0101);

      // SPI: 1 byte, TDC returns 0x3C
      loopback = 1'b0;
      tdc_pat  = 24'h3C0000;
      start_xfer(2'd1, 24'hA50000);
      check("x1_busy", xfer_busy, 1);
      check("x1_csb", tdc_csb, 0);
      check("x1_din0", tdc_din, 1);
      check("x1_sclk", tdc_sclk, 0);
      watch(-1, ncyc, frise, dbits);
      check("x1_busy_cycles", ncyc, 34);
      check("x1_first_rise", frise, 2);
      check("x1_din_bits", dbits[7:0], 8'hA5);
      check("x1_done", xfer_done, 1);
      check("x1_rx", xfer_rx, 24'h00003C);
      check("x1_csb_end", tdc_csb, 1);

      // SPI: 3 bytes loopback, started in the done cycle, stray start while busy
      loopback = 1'b1;
      start_xfer(2'd3, 24'h81FF00);
      check("x3_busy", xfer_busy, 1);
      watch(10, ncyc, frise, dbits);
      check("x3_busy_cycles", ncyc, 98);
      check("x3_din_bits", dbits, 24'h81FF00);
      check("x3_done", xfer_done, 1);
      check("x3_rx", xfer_rx, 24'h81FF00);
      step();
      check("x3_done_pulse", xfer_done, 0);

      // nbytes=0 is ignored
      start_xfer(2'd0, 24'hFFFFFF);
      check("x0_busy", xfer_busy, 0);
      check("x0_csb", tdc_csb, 1);

      // Reset mid-transfer at bit 5
      loopback = 1'b0;
      tdc_pat  = 24'hFFFFFF;
      start_xfer(2'd2, 24'h123456);
      rises = 0;
      for (int i = 0; i < 200 && rises < 5; i++) begin
         prev = tdc_sclk;
         step();
         if (tdc_sclk && !prev) rises++;
      end
      check("mid_rises", rises, 5);
      tstamp_rst = 1'b1; step(); tstamp_rst = 1'b0;
      check("mid_csb", tdc_csb, 1);
      check("mid_sclk", tdc_sclk, 0);
      check("mid_busy", xfer_busy, 0);
      check("mid_rx", xfer_rx, 24'h0);
      check("mid_valid", ch_valid, 4'b0000);
      done_seen = xfer_done ? 1 : 0;
      repeat (80) begin
         step();
         if (xfer_done) done_seen++;
      end
      check("mid_no_done", done_seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
